encode_woe_ctrl: RTL and testbench

//  Sequencer for the Wo/energy joint VQ in the 2400 encoder. Per frame: runs compute_weights on the latched x[0..1] and held xq[0..1], then scans the ge codebook ROM.

---
 rtl/encode_woe_ctrl_pkg.sv | 43 ++++
 rtl/encode_woe_ctrl_dist.sv | 21 ++
 rtl/encode_woe_ctrl.sv | 128 ++++++++++++
 tb/tb_encode_woe_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/encode_woe_ctrl_pkg.sv
// encode_woe_ctrl_pkg: shared widths, Q16 coefficients, FSM encodings and signed-magnitude fixed-point helpers
package encode_woe_ctrl_pkg;
  localparam int N = 32;
  localparam int Q = 16;
  localparam int CB_BITS_DEF = 8;
  localparam int CW_TIMEOUT_DEF = 32;
  typedef logic [N-1:0] word_t;
  localparam word_t C08 = 32'h0000_CCCD;
  localparam word_t C09 = 32'h0000_E666;
  localparam word_t ERR_MAX = 32'h7FFF_FFFF;
  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] CW_RUN = 4'd1;
  localparam logic [3:0] TARGET = 4'd2;
  localparam logic [3:0] SEARCH = 4'd3;
  localparam logic [3:0] DRAIN1 = 4'd4;
  localparam logic [3:0] DRAIN2 = 4'd5;
  localparam logic [3:0] UPD_A = 4'd6;
  localparam logic [3:0] UPD_B = 4'd7;
  localparam logic [3:0] DONE = 4'd8;
  function automatic word_t qmult(word_t a, word_t b);
    logic [N-2:0] m;
    m = (N-1)'(({{Q{1'b0}}, a[N-2:0]} * {{Q{1'b0}}, b[N-2:0]}) >> Q);
    return {(a[N-1] ^ b[N-1]) & |m, m};
  endfunction
  function automatic word_t qadd(word_t a, word_t b);
    logic [N-2:0] m;
    logic s;
    if (a[N-1] == b[N-1]) begin
      m = a[N-2:0] + b[N-2:0];
      s = a[N-1];
    end else if (a[N-2:0] >= b[N-2:0]) begin
      m = a[N-2:0] - b[N-2:0];
      s = a[N-1];
    end else begin
      m = b[N-2:0] - a[N-2:0];
      s = b[N-1];
    end
    return {s & |m, m};
  endfunction
  function automatic word_t qsub(word_t a, word_t b);
    return qadd(a, {~b[N-1], b[N-2:0]});
  endfunction
endpackage

// File: rtl/encode_woe_ctrl_dist.sv
// encode_woe_ctrl_dist: registered weighted squared distance w0*(t0-e0)^2 + w1*(t1-e1)^2
module encode_woe_ctrl_dist
  import encode_woe_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] t0,
  input  logic [N-1:0] t1,
  input  logic [N-1:0] w0,
  input  logic [N-1:0] w1,
  input  logic [N-1:0] e0,
  input  logic [N-1:0] e1,
  output logic [N-1:0] d
);
  logic [N-1:0] r0, r1;
  assign r0 = qsub(t0, e0);
  assign r1 = qsub(t1, e1);
  always_ff @(posedge clk or posedge rst)
    if (rst) d <= '0;
    else d <= qadd(qmult(w0, qmult(r0, r0)), qmult(w1, qmult(r1, r1)));
endmodule

// File: rtl/encode_woe_ctrl.sv
// encode_woe_ctrl: Wo/energy joint VQ sequencer (compute_weights, codebook scan, predictor update)
// WOE_TIE_LAST_EN defined: last of equal minima wins; otherwise the lowest index wins.
module encode_woe_ctrl
  import encode_woe_ctrl_pkg::*;
#(
  parameter int CB_BITS = CB_BITS_DEF,
  parameter int CW_TIMEOUT = CW_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N-1:0]       x0,
  input  logic [N-1:0]       x1,
  output logic               cw_rst_n,
  output logic [N-1:0]       cw_x0,
  output logic [N-1:0]       cw_x1,
  output logic [N-1:0]       cw_xp0,
  output logic [N-1:0]       cw_xp1,
  input  logic [N-1:0]       w0,
  input  logic [N-1:0]       w1,
  input  logic               done_cw,
  output logic [CB_BITS-1:0] cb_addr,
  input  logic [N-1:0]       cb_e0,
  input  logic [N-1:0]       cb_e1,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CB_BITS-1:0] n1,
  output logic [N-1:0]       xq0,
  output logic [N-1:0]       xq1
);
  localparam int TW = $clog2(CW_TIMEOUT + 1);
  logic [3:0] state;
  logic [N-1:0] lx0, lx1, t0, t1, d, best_err;
  logic [CB_BITS-1:0] addr, cmp_idx, best_idx;
  logic [TW-1:0] tcnt;
  logic v1, v2, abort, better;
  assign cw_rst_n = busy;
  assign cw_x0 = lx0;
  assign cw_x1 = lx1;
  assign cw_xp0 = xq0;
  assign cw_xp1 = xq1;
  assign cb_addr = state == UPD_A ? best_idx : addr;
  assign done = state == DONE;
  assign err = done & abort;
`ifdef WOE_TIE_LAST_EN
  assign better = (d & ERR_MAX) <= best_err;
`else
  assign better = (d & ERR_MAX) < best_err;
`endif
  encode_woe_ctrl_dist u_dist (
    .clk(clk), .rst(rst), .t0(t0), .t1(t1), .w0(w0), .w1(w1),
    .e0(cb_e0), .e1(cb_e1), .d(d)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      lx0 <= '0;
      lx1 <= '0;
      t0 <= '0;
      t1 <= '0;
      best_err <= '0;
      addr <= '0;
      cmp_idx <= '0;
      best_idx <= '0;
      tcnt <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      abort <= 1'b0;
      busy <= 1'b0;
      n1 <= '0;
      xq0 <= '0;
      xq1 <= '0;
    end else begin
      v1 <= state == SEARCH;
      v2 <= v1;
      case (state)
        IDLE: if (start) begin
          lx0 <= x0;
          lx1 <= x1;
          busy <= 1'b1;
          abort <= 1'b0;
          tcnt <= '0;
          state <= CW_RUN;
        end
        CW_RUN: if (done_cw) state <= TARGET;
          else if (tcnt == TW'(CW_TIMEOUT - 1)) begin
            abort <= 1'b1;
            state <= DONE;
          end else tcnt <= tcnt + 1'b1;
        TARGET: begin
          t0 <= qsub(lx0, qmult(C08, xq0));
          t1 <= qsub(lx1, qmult(C09, xq1));
          best_err <= ERR_MAX;
          best_idx <= '0;
          cmp_idx <= '0;
          addr <= '0;
          state <= SEARCH;
        end
        SEARCH: begin
          addr <= addr + 1'b1;
          if (&addr) state <= DRAIN1;
        end
        DRAIN1: state <= DRAIN2;
        DRAIN2: state <= UPD_A;
        UPD_A: state <= UPD_B;
        UPD_B: begin
          xq0 <= qadd(qmult(C08, xq0), cb_e0);
          xq1 <= qadd(qmult(C09, xq1), cb_e1);
          n1 <= best_idx;
          state <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // distance for address k arrives two cycles after k was issued
      if (v2) begin
        cmp_idx <= cmp_idx + 1'b1;
        if (better) begin
          best_err <= d & ERR_MAX;
          best_idx <= cmp_idx;
        end
      end
    end
endmodule

// File: tb/tb_encode_woe_ctrl.sv
// tb_encode_woe_ctrl: directed frames checked against an integer model of the VQ search
module tb_encode_woe_ctrl;
  localparam int CB = 2;
  localparam int M = 4;
  localparam int TO = 32;
  localparam longint K08 = 52429;
  localparam longint K09 = 58982;
`ifdef WOE_TIE_LAST_EN
  localparam bit TIE_LAST = 1;
`else
  localparam bit TIE_LAST = 0;
`endif
  logic clk = 0, rst = 1, start = 0, done_cw = 0;
  logic [31:0] x0 = 0, x1 = 0, w0 = 32'h10000, w1 = 32'h10000, cb_e0 = 0, cb_e1 = 0;
  logic cw_rst_n, busy, done, err;
  logic [31:0] cw_x0, cw_x1, cw_xp0, cw_xp1, xq0, xq1;
  logic [CB-1:0] cb_addr, n1;
  logic [31:0] rom0 [M];
  logic [31:0] rom1 [M];
  int total = 0, bad = 0, ndone = 0;
  logic [31:0] lx0 = 0, lx1 = 0, exp_xp0 = 0, exp_xp1 = 0, exp_xq0 = 0, exp_xq1 = 0;
  logic [CB-1:0] exp_n1 = 0, last_n1 = 0;
  logic exp_err = 0;
  longint mxq0 = 0, mxq1 = 0;
  int lat;

  encode_woe_ctrl #(.CB_BITS(CB), .CW_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .x1(x1), .cw_rst_n(cw_rst_n),
    .cw_x0(cw_x0), .cw_x1(cw_x1), .cw_xp0(cw_xp0), .cw_xp1(cw_xp1),
    .w0(w0), .w1(w1), .done_cw(done_cw), .cb_addr(cb_addr), .cb_e0(cb_e0), .cb_e1(cb_e1),
    .busy(busy), .done(done), .err(err), .n1(n1), .xq0(xq0), .xq1(xq1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cb_e0 <= rom0[cb_addr];
    cb_e1 <= rom1[cb_addr];
  end

  task automatic chk(input string nm, input longint a, input longint e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask

  function automatic longint to_i(logic [31:0] v);
    return v[31] ? -longint'(v[30:0]) : longint'(v[30:0]);
  endfunction

  function automatic logic [31:0] to_sm(longint v);
    longint a;
    a = v < 0 ? -v : v;
    return {v < 0, a[30:0]};
  endfunction

  function automatic longint qm(longint a, longint b);
    return (a * b) / 65536;
  endfunction

  // argmin over the ROM of w*(t-e)^2 with truncating Q16 products
  task automatic model(input logic [31:0] a0, input logic [31:0] a1);
    longint t0, t1, d, best, r0, r1;
    t0 = to_i(a0) - qm(K08, mxq0);
    t1 = to_i(a1) - qm(K09, mxq1);
    best = 64'h7FFF_FFFF;
    exp_n1 = 0;
    for (int i = 0; i < M; i++) begin
      r0 = t0 - to_i(rom0[i]);
      r1 = t1 - to_i(rom1[i]);
      d = qm(to_i(w0), qm(r0, r0)) + qm(to_i(w1), qm(r1, r1));
      if (d < best || (TIE_LAST && d == best)) begin
        best = d;
        exp_n1 = CB'(i);
      end
    end
    exp_xq0 = to_sm(qm(K08, mxq0) + to_i(rom0[exp_n1]));
    exp_xq1 = to_sm(qm(K09, mxq1) + to_i(rom1[exp_n1]));
  endtask

  task automatic set_rom(input logic [31:0] r [8]);
    for (int i = 0; i < M; i++) begin
      rom0[i] = r[2*i];
      rom1[i] = r[2*i+1];
    end
  endtask

  task automatic frame(input logic [31:0] a0, input logic [31:0] a1, input int cw_wait,
                       input bit timeout, input bit poke, output int l);
    int nd0;
    nd0 = ndone;
    model(a0, a1);
    exp_err = timeout;
    exp_xp0 = to_sm(mxq0);
    exp_xp1 = to_sm(mxq1);
    if (timeout) begin
      exp_n1 = last_n1;
      exp_xq0 = exp_xp0;
      exp_xq1 = exp_xp1;
    end
    lx0 = a0;
    lx1 = a1;
    @(negedge clk);
    x0 = a0;
    x1 = a1;
    start = 1;
    @(negedge clk);
    start = 0;
    x0 = 32'h0BAD_0000;
    x1 = 32'h8123_4567;
    l = 1;
    if (!timeout) begin
      repeat (cw_wait) @(negedge clk);
      done_cw = 1;
      l = 0;
    end
    while (!done && l < 200) begin
      @(negedge clk);
      l++;
      if (poke && l == 4) begin
        start = 1;
        x0 = 32'h0007_0000;
      end else start = 0;
    end
    chk("done_seen", done, 1);
    start = 0;
    done_cw = 0;
    if (!timeout) begin
      mxq0 = to_i(exp_xq0);
      mxq1 = to_i(exp_xq1);
      last_n1 = exp_n1;
    end
    repeat (6) @(negedge clk);
    chk("single_done", ndone, nd0 + 1);
    chk("busy_after", busy, 0);
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (busy && !done) begin
        chk("cw_x0", cw_x0, lx0);
        chk("cw_x1", cw_x1, lx1);
        chk("cw_xp0", cw_xp0, exp_xp0);
        chk("cw_xp1", cw_xp1, exp_xp1);
        chk("cw_rst_n", cw_rst_n, 1);
      end
      if (done) begin
        ndone++;
        chk("n1", n1, exp_n1);
        chk("xq0", xq0, exp_xq0);
        chk("xq1", xq1, exp_xq1);
        chk("err", err, exp_err);
        chk("busy_at_done", busy, 1);
      end else chk("err_idle", err, 0);
    end

  initial begin
    logic [31:0] r2 [8] = '{32'h0, 32'h0, 32'h20000, 32'hA0000, 32'h50000, 32'h50000, 32'h10000, 32'h10000};
    logic [31:0] r3 [8] = '{32'h0, 32'h0, 32'h30000, 32'h40000, 32'h10000, 32'h10000, 32'h30000, 32'h40000};
    set_rom(r2);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cw_rst_n", cw_rst_n, 0);
    chk("rst_xq0", xq0, 0);
    chk("rst_n1", n1, 0);
    chk("rst_addr", cb_addr, 0);
    rst = 0;
    frame(32'h20000, 32'hA0000, 3, 0, 0, lat);
    chk("t2_lat", lat, 10);
    chk("t2_n1", n1, 1);
    chk("t2_xq0", xq0, 32'h20000);
    chk("t2_xq1", xq1, 32'hA0000);
    frame(32'h20000, 32'hA0000, 1, 0, 0, lat);
    chk("t5_lat", lat, 10);
    chk("t5_n1", n1, 3);
    chk("t5_model_xq0", exp_xq0, 32'h2999A);
    chk("t5_xq0", xq0, 32'h2999A);
    chk("t5_xq1", xq1, 32'h9FFFC);
    lx0 = 32'h30000;
    lx1 = 32'h40000;
    exp_xp0 = xq0;
    exp_xp1 = xq1;
    @(negedge clk);
    x0 = 32'h30000;
    x1 = 32'h40000;
    start = 1;
    @(negedge clk);
    start = 0;
    done_cw = 1;
    repeat (4) @(negedge clk);
    rst = 1;
    #1 done_cw = 0;
    @(negedge clk);
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 0);
    chk("t1_cw_rst_n", cw_rst_n, 0);
    chk("t1_xq0", xq0, 0);
    chk("t1_xq1", xq1, 0);
    chk("t1_n1", n1, 0);
    rst = 0;
    mxq0 = 0;
    mxq1 = 0;
    last_n1 = 0;
    set_rom(r3);
    frame(32'h30000, 32'h40000, 2, 0, 0, lat);
    chk("t3_n1", n1, TIE_LAST ? 3 : 1);
    chk("t3_xq0", xq0, 32'h30000);
    frame(32'h18000, 32'h50000, 0, 0, 1, lat);
    chk("t6_lat", lat, 10);
    frame(32'h10000, 32'h10000, 0, 1, 0, lat);
    chk("t4_lat", lat, TO + 1);
    chk("t4_n1", n1, last_n1);
    chk("t4_xq0", xq0, to_sm(mxq0));
    chk("t4_xq1", xq1, to_sm(mxq1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
